// File: rtl/button_conditioner_if.sv
// Push-button bundle: raw pad input toward the conditioner and the conditioned
// level/pulse outputs back toward the count logic.
interface button_conditioner_if;
    logic button;
    logic btn_level;
    logic btn_rise;
    logic btn_fall;
    logic btn_repeat;
    logic btn_event;

    modport master (
        output button,
        input  btn_level,
        input  btn_rise,
        input  btn_fall,
        input  btn_repeat,
        input  btn_event
    );

    modport slave (
        input  button,
        output btn_level,
        output btn_rise,
        output btn_fall,
        output btn_repeat,
        output btn_event
    );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises and debounces a raw push-button, producing a clean level,
// press/release pulses and optional auto-repeat pulses for the count enable.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter int unsigned REPEAT_DELAY    = 5000000,
    parameter int unsigned REPEAT_PERIOD   = 1000000,
    parameter int unsigned CNT_W           = 24
) (
    input  logic                 clk_10mhz,
    input  logic                 rst,
    button_conditioner_if.slave  bus_if
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ARM_HIGH = 2'd1;
    localparam logic [1:0] S_PRESSED  = 2'd2;
    localparam logic [1:0] S_ARM_LOW  = 2'd3;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic             sync1_q, sync2_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             first_q, first_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             rep_q, rep_d;
    logic             event_q, event_d;

    // Two-flop synchroniser; only sync2_q is seen by the FSM
    always_ff @(posedge clk_10mhz or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus_if.button;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk_10mhz or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            dcnt_q  <= '0;
            rcnt_q  <= '0;
            first_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            rep_q   <= 1'b0;
            event_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            rcnt_q  <= rcnt_d;
            first_q <= first_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            rep_q   <= rep_d;
            event_q <= event_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        rcnt_d  = rcnt_q;
        first_d = first_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        rep_d   = 1'b0;
        event_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sync2_q) begin
                    state_d = S_ARM_HIGH;
                    dcnt_d  = CNT_W'(1);
                end
            end
            S_ARM_HIGH: begin
                if (!sync2_q) begin
                    state_d = S_IDLE;
                    dcnt_d  = '0;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d = S_PRESSED;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                    event_d = 1'b1;
                    dcnt_d  = '0;
                    rcnt_d  = '0;
                    first_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + CNT_W'(1);
                end
            end
            S_PRESSED: begin
                // Repeat counter freezes while a release is being qualified
                if (!sync2_q) begin
                    state_d = S_ARM_LOW;
                    dcnt_d  = CNT_W'(1);
                end else if (REPEAT_EN) begin
                    if (first_q ? (rcnt_q == DLY_LAST) : (rcnt_q == PER_LAST)) begin
                        rep_d   = 1'b1;
                        event_d = 1'b1;
                        rcnt_d  = '0;
                        first_d = 1'b0;
                    end else begin
                        rcnt_d = rcnt_q + CNT_W'(1);
                    end
                end
            end
            S_ARM_LOW: begin
                if (sync2_q) begin
                    state_d = S_PRESSED;
                    dcnt_d  = '0;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d = S_IDLE;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus_if.btn_level  = level_q;
    assign bus_if.btn_rise   = rise_q;
    assign bus_if.btn_fall   = fall_q;
    assign bus_if.btn_repeat = rep_q;
    assign bus_if.btn_event  = event_q;

endmodule
